sipo: RTL and testbench
=======================

# sipo

Serial-in, parallel-out deserializer. It sits directly downstream of the parallel-in, serial-out buffer in the serial datapath and consumes its one-bit valid/ready stream. It reassembles `DATA_BITS`-wide words, least-significant bit first, and presents each word on a parallel valid/ready port. A one-word holding slot lets the next word collect while the previous one waits for the consumer.

## Interface
- `DATA_BITS`, default 8: word width. Legal range is 2 or more.
- `clk`  in  1  clock. All state changes on the rising edge.
- `rst`  in  1  reset. Asynchronous, active-low: `rst`=0 resets immediately.
- `input_valid`  in  1  serial bit is present.
- `input_bit`  in  1  serial data bit.
- `input_ready`  out  1  block accepts a bit this cycle.
- `output_valid`  out  1  assembled word is available.
- `output_data`  out  `DATA_BITS`  assembled word.
- `output_ready`  in  1  consumer takes the word this cycle.

## Operation
- Transfers:
  - A bit transfers on a rising edge where `input_valid && input_ready`.
  - A word transfers on a rising edge where `output_valid && output_ready`.
- Internal state:
  - `shift` (`DATA_BITS` wide).
  - `count` (width `$clog2(DATA_BITS)`, range 0..`DATA_BITS`-1).
  - `hold` (`DATA_BITS` wide).
  - `hold_valid` (1 bit).
- Bit ordering: the first bit received is bit 0 of the word. On each accepted bit, `shift <= {input_bit, shift[DATA_BITS-1:1]}`.
- Collect rule:
  - On an accepted bit with `count` < `DATA_BITS`-1: update `shift` and increment `count`.
- Complete rule:
  - On an accepted bit with `count` == `DATA_BITS`-1: load `hold <= {input_bit, shift[DATA_BITS-1:1]}`, set `hold_valid`, and wrap `count` to 0.
  - `shift` contents after completion are don't-care.
- Hold slot, two states:
  - EMPTY to FULL on completion.
  - FULL to EMPTY on a word transfer.
  - FULL stays FULL while `output_ready`=0.
- `output_valid = hold_valid` and `output_data = hold`. Both are direct register outputs.
- `input_ready = !(count == DATA_BITS-1 && hold_valid)`.
  - There is no combinational path from `output_ready` to `input_ready`.
  - Bits 0..`DATA_BITS`-2 of the next word are always accepted, even while `hold` is FULL.
- Simultaneous events:
  - A word drains on the same edge that a non-final bit is accepted: both take effect.
  - Completion can never coincide with a drain of the same slot. `input_ready` is low in that case, so the slot is always EMPTY at completion.
- `input_valid` gaps are allowed at any point. `count` and `shift` hold their values across idle cycles.
- `output_data` is held stable while `output_valid && !output_ready`.

## Timing
- Reset values while `rst`=0:
  - `input_ready`=1, `output_valid`=0, `output_data`=0.
  - `count`=0, `shift`=0.
- Reset mid-operation discards the partial word and any held word. The first bit accepted after release is bit 0 of a new word.
- Latency: if the final bit is accepted at edge N, `output_valid`=1 in the cycle after edge N.
- Throughput:
  - One bit per cycle sustained when the consumer drains each word within `DATA_BITS`-1 cycles of `output_valid` rising.
  - Otherwise `input_ready` drops while `count`==`DATA_BITS`-1 and rises in the cycle after the drain edge.
- Protocol rules on the neighbours:
  - Upstream must not retract `input_valid` or change `input_bit` before the bit transfers.
  - The block guarantees the same rule for `output_valid`/`output_data`.

## Structure
- Shared package `serial_pkg` (used by this block and the piso):
  - `DEFAULT_DATA_BITS` = 8.
  - `count_width(bits)` function.
  - Empty-word constant.
- One sub-module is natural: `hold_slot`, a single-entry valid/ready register holding `hold` and `hold_valid`.
  - Inputs: load-enable and load data.
  - Outputs: `output_valid`, `output_data` and a `full` flag, which feeds the `input_ready` equation.
- The shift/count logic stays in the top level.

## Test plan
- Single word: `DATA_BITS`=8, bits 1,0,1,0,0,1,0,1 on consecutive cycles, `output_ready`=1 → `output_valid` pulses for 1 cycle with `output_data`=0xA5, one cycle after the 8th bit.
- Back-to-back: stream 0x3C then 0xC3 (16 bits in 16 cycles), `output_ready`=1 → `input_ready` stays 1 throughout; words 0x3C then 0xC3 appear 8 cycles apart.
- Backpressure: `output_ready`=0, send 0x01 then 7 bits of 0x80 → `input_ready` falls after the 7th bit and `output_data` holds 0x01. Raise `output_ready` for 1 cycle → 0x01 drains and `input_ready` rises next cycle. Send the final bit, `output_ready`=1 → 0x80 appears.
- Gapped input: 0xF0 sent with random 0–5 idle cycles between bits → `output_data`=0xF0, no extra words.
- Reset mid-word: 5 bits sent, then `rst`=0 for 1 cycle → immediately `output_valid`=0 and `input_ready`=1. Then send 0xFF → exactly one word, 0xFF.
- Reset with held word: `hold` FULL (0x5A), `output_ready`=0, `rst` pulsed → `output_valid`=0 immediately; 0x5A is never delivered.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial datapath (sipo and piso).
package serial_pkg;

  localparam int unsigned DEFAULT_DATA_BITS = 8;

  // Value presented on an empty or freshly reset word port.
  localparam logic [DEFAULT_DATA_BITS-1:0] EMPTY_WORD = '0;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  // Width of a bit counter spanning 0..bits-1; never narrower than one bit.
  function automatic int unsigned count_width(input int unsigned bits);
    return (bits > 1) ? $clog2(bits) : 1;
  endfunction

endpackage

// File: rtl/sipo_if.sv
// Serial bit stream in, parallel word stream out, both valid/ready.
interface sipo_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 input_valid;
  logic                 input_bit;
  logic                 input_ready;
  logic                 output_valid;
  logic [DATA_BITS-1:0] output_data;
  logic                 output_ready;

  // Environment side: drives the serial bits and the word consumer's ready.
  modport master (
    output input_valid, input_bit, output_ready,
    input  input_ready, output_valid, output_data
  );

  // Deserializer side.
  modport slave (
    input  input_valid, input_bit, output_ready,
    output input_ready, output_valid, output_data
  );
endinterface

// File: rtl/sipo_hold_slot.sv
// Single-entry valid/ready holding register for completed words.
module hold_slot
  import serial_pkg::*;
#(
  parameter int unsigned DATA_BITS = DEFAULT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] load_data,
  input  logic                 output_ready,
  output logic                 output_valid,
  output logic [DATA_BITS-1:0] output_data,
  output logic                 full
);

  slot_state_t state, state_next;

  // Slot occupancy register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= SLOT_EMPTY;
    else      state <= state_next;
  end

  // Next occupancy: fill on load, empty on a word transfer.
  always_comb begin
    state_next = state;
    case (state)
      SLOT_EMPTY: if (load)         state_next = SLOT_FULL;
      SLOT_FULL:  if (output_ready) state_next = SLOT_EMPTY;
      default:                      state_next = SLOT_EMPTY;
    endcase
  end

  // Word register; only written on load so it stays stable while waiting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      output_data <= '0;
    else if (load) output_data <= load_data;
  end

  assign full         = (state == SLOT_FULL);
  assign output_valid = full;

endmodule

// File: rtl/sipo.sv
// Serial-in parallel-out deserializer, LSB first, with one-word holding slot.
module sipo
  import serial_pkg::*;
#(
  parameter int unsigned DATA_BITS = DEFAULT_DATA_BITS
) (
  input logic   clk,
  input logic   rst,
  sipo_if.slave bus
);

  localparam int unsigned CW = count_width(DATA_BITS);
  localparam logic [CW-1:0] LAST = CW'(DATA_BITS - 1);

  logic [DATA_BITS-1:0] shift;
  logic [CW-1:0]        count;
  logic                 full;
  logic                 at_last;
  logic                 accept;
  logic                 complete;

  assign at_last         = (count == LAST);
  assign bus.input_ready = !(at_last && full);
  assign accept          = bus.input_valid && bus.input_ready;
  assign complete        = accept && at_last;

  // Shift in accepted bits and track position within the word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift <= '0;
      count <= '0;
    end else if (accept) begin
      shift <= {bus.input_bit, shift[DATA_BITS-1:1]};
      count <= at_last ? '0 : count + CW'(1);
    end
  end

  hold_slot #(.DATA_BITS(DATA_BITS)) u_hold (
    .clk          (clk),
    .rst          (rst),
    .load         (complete),
    .load_data    ({bus.input_bit, shift[DATA_BITS-1:1]}),
    .output_ready (bus.output_ready),
    .output_valid (bus.output_valid),
    .output_data  (bus.output_data),
    .full         (full)
  );

endmodule

// File: tb/tb_sipo.sv
// Directed self-checking bench for sipo (DATA_BITS = 8).
module tb_sipo;

  logic clk;
  logic rst;
  int   checks;
  int   fails;
  int   words_seen;
  logic [7:0] last_word;
  logic [7:0] w;

  sipo_if #(.DATA_BITS(8)) bus ();

  sipo #(.DATA_BITS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance to the next falling edge (one rising edge consumed) and log any
  // word visible there.
  task automatic tick();
    @(negedge clk);
    if (bus.output_valid) begin
      words_seen++;
      last_word = bus.output_data;
    end
  endtask

  task automatic drive(input logic v, input logic b, input logic r);
    bus.input_valid  = v;
    bus.input_bit    = b;
    bus.output_ready = r;
  endtask

  task automatic pulse_reset();
    #1 rst = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    checks = 0; fails = 0; words_seen = 0; last_word = '0;
    drive(1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_input_ready", 32'(bus.input_ready), 32'd1);
    check("reset_output_valid", 32'(bus.output_valid), 32'd0);
    check("reset_output_data", 32'(bus.output_data), 32'h00);
    rst = 1'b1;
    tick();

    // Single word 0xA5, consumer ready.
    w = 8'hA5;
    for (int unsigned i = 0; i < 8; i++) begin
      drive(1'b1, w[i], 1'b1);
      tick();
      if (i == 6) check("single_not_early", 32'(bus.output_valid), 32'd0);
    end
    check("single_valid", 32'(bus.output_valid), 32'd1);
    check("single_data", 32'(bus.output_data), 32'hA5);
    drive(1'b0, 1'b0, 1'b1);
    tick();
    check("single_pulse_once", 32'(bus.output_valid), 32'd0);

    // Back-to-back 0x3C then 0xC3.
    for (int unsigned i = 0; i < 16; i++) begin
      w = (i < 8) ? 8'h3C : 8'hC3;
      check("b2b_input_ready", 32'(bus.input_ready), 32'd1);
      drive(1'b1, w[i % 8], 1'b1);
      tick();
      check("b2b_valid", 32'(bus.output_valid), 32'((i == 7) || (i == 15)));
      if (i == 7)  check("b2b_word0", 32'(bus.output_data), 32'h3C);
      if (i == 15) check("b2b_word1", 32'(bus.output_data), 32'hC3);
    end
    drive(1'b0, 1'b0, 1'b1);
    tick();

    // Backpressure: 0x01 held while 7 bits of 0x80 collect.
    w = 8'h01;
    for (int unsigned i = 0; i < 8; i++) begin
      drive(1'b1, w[i], 1'b0);
      tick();
    end
    check("bp_word0_valid", 32'(bus.output_valid), 32'd1);
    check("bp_word0_data", 32'(bus.output_data), 32'h01);
    for (int unsigned i = 0; i < 7; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      tick();
      check("bp_input_ready", 32'(bus.input_ready), 32'(i != 6));
    end
    check("bp_hold_stable", 32'(bus.output_data), 32'h01);
    check("bp_hold_valid", 32'(bus.output_valid), 32'd1);
    drive(1'b1, 1'b1, 1'b0);
    tick();
    check("bp_final_blocked", 32'(bus.output_valid), 32'd1);
    check("bp_final_blocked_data", 32'(bus.output_data), 32'h01);
    drive(1'b0, 1'b0, 1'b1);
    tick();
    check("bp_drained", 32'(bus.output_valid), 32'd0);
    check("bp_ready_back", 32'(bus.input_ready), 32'd1);
    drive(1'b1, 1'b1, 1'b1);
    tick();
    check("bp_word1_valid", 32'(bus.output_valid), 32'd1);
    check("bp_word1_data", 32'(bus.output_data), 32'h80);
    drive(1'b0, 1'b0, 1'b1);
    tick();

    // Gapped 0xF0.
    words_seen = 0;
    w = 8'hF0;
    for (int unsigned i = 0; i < 8; i++) begin
      automatic int unsigned gap = $urandom_range(0, 5);
      drive(1'b0, 1'b0, 1'b1);
      repeat (gap) tick();
      drive(1'b1, w[i], 1'b1);
      tick();
    end
    drive(1'b0, 1'b0, 1'b1);
    repeat (4) tick();
    check("gap_word_count", 32'(words_seen), 32'd1);
    check("gap_word_data", 32'(last_word), 32'hF0);

    // Reset mid-word after 5 bits.
    for (int unsigned i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b1);
      tick();
    end
    drive(1'b0, 1'b0, 1'b1);
    pulse_reset();
    check("rst_mid_valid", 32'(bus.output_valid), 32'd0);
    check("rst_mid_ready", 32'(bus.input_ready), 32'd1);
    release_reset();
    words_seen = 0;
    for (int unsigned i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 1'b1);
      tick();
    end
    drive(1'b0, 1'b0, 1'b1);
    repeat (3) tick();
    check("rst_mid_word_count", 32'(words_seen), 32'd1);
    check("rst_mid_word_data", 32'(last_word), 32'hFF);

    // Reset with a held word 0x5A.
    w = 8'h5A;
    for (int unsigned i = 0; i < 8; i++) begin
      drive(1'b1, w[i], 1'b0);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0);
    tick();
    check("held_valid", 32'(bus.output_valid), 32'd1);
    check("held_data", 32'(bus.output_data), 32'h5A);
    pulse_reset();
    check("held_rst_valid", 32'(bus.output_valid), 32'd0);
    check("held_rst_data", 32'(bus.output_data), 32'h00);
    release_reset();
    words_seen = 0;
    drive(1'b0, 1'b0, 1'b1);
    repeat (4) tick();
    check("held_never_delivered", 32'(words_seen), 32'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
